sequential_to_simultaneous_reg: RTL

//  Serial-to-parallel collector; inverse of the parallel-to-serial shift register on the BCH datapath.

---
 rtl/sequential_to_simultaneous_reg_pkg.sv | 15 +
 rtl/clk_distance_ticker.sv | 45 ++++
 rtl/sequential_to_simultaneous_reg.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sequential_to_simultaneous_reg_pkg.sv
// Shared sizing helpers for the BCH serializer / collector pair, so both ends
// derive the tick distance and fill-counter width identically.
package sequential_to_simultaneous_reg_pkg;

    // Clamp a count-like parameter to at least 1.
    function automatic int not_being_zero(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    // Bits needed to hold a counter running 0..count-1 (never less than one bit).
    function automatic int bit_width_cal(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/clk_distance_ticker.sv
// Enable-gated divider: asserts tick on every DISTANCE-th enabled cycle.
// Shared with the serializer so sample spacing matches on both ends.
module clk_distance_ticker
    import sequential_to_simultaneous_reg_pkg::*;
#(
    parameter int DISTANCE = 1
) (
    input  logic clk,
    input  logic in_ctr_Srst,
    input  logic in_ctr_clr,
    input  logic in_ctr_en,
    output logic tick
);

    localparam int D = not_being_zero(DISTANCE);

    generate
        if (D == 1) begin : g_every_cycle
            logic unused_s;
            assign unused_s = ^{clk, in_ctr_Srst, in_ctr_clr, in_ctr_en};
            assign tick     = 1'b1;
        end else begin : g_divided
            localparam int CW = $clog2(D);
            localparam logic [CW-1:0] LAST = CW'(D - 1);

            logic [CW-1:0] tick_cnt_r;

            // Tick counter: clear wins over enable, wraps after the last phase.
            always_ff @(posedge clk) begin
                if (in_ctr_Srst) begin
                    tick_cnt_r <= {CW{1'b0}};
                end else if (in_ctr_clr) begin
                    tick_cnt_r <= {CW{1'b0}};
                end else if (in_ctr_en) begin
                    tick_cnt_r <= (tick_cnt_r == LAST) ? {CW{1'b0}} : tick_cnt_r + CW'(1'b1);
                end else begin
                    tick_cnt_r <= tick_cnt_r;
                end
            end

            assign tick = (tick_cnt_r == LAST);
        end
    endgenerate

endmodule

// File: rtl/sequential_to_simultaneous_reg.sv
// Serial-to-parallel collector: gathers SHIFT_LEN words into a frame and
// presents it on a held output buffer with a one-cycle out_valid strobe.
module sequential_to_simultaneous_reg
    import sequential_to_simultaneous_reg_pkg::*;
#(
    parameter int DIRECTION    = 1,
    parameter int SHIFT_LEN    = 1,
    parameter int BIT_WIDTH    = 2,
    parameter int CLK_DISTANCE = 1
) (
    input  logic                                             clk,
    input  logic                                             in_ctr_Srst,
    input  logic                                             in_ctr_init,
    input  logic                                             in_ctr_en,
    input  logic [BIT_WIDTH-1:0]                             in,
    output logic [not_being_zero(BIT_WIDTH*SHIFT_LEN)-1:0]   out,
    output logic                                             out_valid,
    output logic [bit_width_cal(SHIFT_LEN)-1:0]              out_fill
);

    localparam int FW = bit_width_cal(SHIFT_LEN);
    localparam int OW = not_being_zero(BIT_WIDTH * SHIFT_LEN);

    logic tick_s;

    clk_distance_ticker #(
        .DISTANCE (CLK_DISTANCE)
    ) u_ticker (
        .clk         (clk),
        .in_ctr_Srst (in_ctr_Srst),
        .in_ctr_clr  (in_ctr_init),
        .in_ctr_en   (in_ctr_en),
        .tick        (tick_s)
    );

    generate
        if (SHIFT_LEN == 0) begin : g_empty
            $warning("sequential_to_simultaneous_reg: SHIFT_LEN is 0, out_valid tied low");
            logic unused_s;
            assign unused_s  = ^{in, in_ctr_init, in_ctr_en, in_ctr_Srst, tick_s};
            assign out       = {OW{1'b0}};
            assign out_valid = 1'b0;
            assign out_fill  = {FW{1'b0}};
        end else if (SHIFT_LEN == 1) begin : g_single
            logic [BIT_WIDTH-1:0] out_r;
            logic                 out_valid_r;

            // Every sample (including an init-restart sample) is a whole frame.
            always_ff @(posedge clk) begin
                if (in_ctr_Srst) begin
                    out_r       <= {BIT_WIDTH{1'b0}};
                    out_valid_r <= 1'b0;
                end else if (in_ctr_en && (in_ctr_init || tick_s)) begin
                    out_r       <= in;
                    out_valid_r <= 1'b1;
                end else begin
                    out_r       <= out_r;
                    out_valid_r <= 1'b0;
                end
            end

            assign out       = out_r;
            assign out_valid = out_valid_r;
            assign out_fill  = {FW{1'b0}};
        end else begin : g_multi
            localparam int            FIRST_SLOT = (DIRECTION > 0) ? SHIFT_LEN - 1 : 0;
            localparam logic [FW-1:0] LAST_FILL  = FW'(SHIFT_LEN - 1);

            logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] asm_r;
            logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] merged_s;
            logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] restart_s;
            logic [SHIFT_LEN-1:0][BIT_WIDTH-1:0] out_r;
            logic [FW-1:0]                       fill_r;
            logic [FW-1:0]                       slot_s;
            logic                                out_valid_r;

            if (DIRECTION > 0) begin : g_forward
                assign slot_s = LAST_FILL - fill_r;
            end else begin : g_backward
                assign slot_s = fill_r;
            end

            // Current word merged into the partial frame, and the one-word frame an init+en starts.
            always_comb begin
                merged_s               = asm_r;
                merged_s[slot_s]       = in;
                restart_s              = {(SHIFT_LEN*BIT_WIDTH){1'b0}};
                restart_s[FIRST_SLOT]  = in;
            end

            // Assembly, fill counter and held output buffer.
            always_ff @(posedge clk) begin
                if (in_ctr_Srst) begin
                    asm_r       <= {(SHIFT_LEN*BIT_WIDTH){1'b0}};
                    fill_r      <= {FW{1'b0}};
                    out_r       <= {(SHIFT_LEN*BIT_WIDTH){1'b0}};
                    out_valid_r <= 1'b0;
                end else if (in_ctr_init) begin
                    out_valid_r <= 1'b0;
                    if (in_ctr_en) begin
                        asm_r  <= restart_s;
                        fill_r <= FW'(1'b1);
                    end else begin
                        asm_r  <= {(SHIFT_LEN*BIT_WIDTH){1'b0}};
                        fill_r <= {FW{1'b0}};
                    end
                end else if (in_ctr_en && tick_s) begin
                    if (fill_r == LAST_FILL) begin
                        out_r       <= merged_s;
                        out_valid_r <= 1'b1;
                        asm_r       <= {(SHIFT_LEN*BIT_WIDTH){1'b0}};
                        fill_r      <= {FW{1'b0}};
                    end else begin
                        out_valid_r <= 1'b0;
                        asm_r       <= merged_s;
                        fill_r      <= fill_r + FW'(1'b1);
                    end
                end else begin
                    out_valid_r <= 1'b0;
                end
            end

            assign out       = out_r;
            assign out_valid = out_valid_r;
            assign out_fill  = fill_r;
        end
    endgenerate

endmodule
